// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared CPU write-back constants: size encodings and requester indices
package wb_arbiter_pkg;

    typedef enum logic [1:0] {
        WE_NONE = 2'b00,
        WE_WORD = 2'b01,
        WE_HALF = 2'b10,
        WE_BYTE = 2'b11
    } we_e;

    localparam int REQ_ALU = 0;
    localparam int REQ_LSU = 1;
    localparam int REQ_CSR = 2;

endpackage

// File: rtl/wb_arbiter_rr_select.sv
// rtl/wb_arbiter_rr_select.sv - round-robin pick: first valid index after ptr, one-hot grant out
module rr_select #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    logic             found;
    logic [IDX_W-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        // Walk the ring starting just past the last winner.
        for (int i = 0; i < N; i++) begin
            idx = IDX_W'((int'(ptr) + 1 + i) % N);
            if (!found && valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin write-back arbiter feeding one registered register-file write port
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NREQ       = 3
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NREQ-1:0]                      req_valid,
    output logic [NREQ-1:0]                      req_ready,
    input  logic [NREQ-1:0][ADDR_WIDTH-1:0]      req_rd,
    input  logic [NREQ-1:0][DATA_WIDTH-1:0]      req_data,
    input  logic [NREQ-1:0][1:0]                 req_size,
    input  logic                                 stall,
    input  logic                                 flush,
    output logic [1:0]                           wr_en,
    output logic [ADDR_WIDTH-1:0]                wr_addr,
    output logic [DATA_WIDTH-1:0]                wr_data,
    output logic [1:0]                           grant_id
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       gnt;
    logic [IDX_W-1:0]      gnt_idx;
    logic                  accept;

    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [1:0]            wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [1:0]            grant_id_q, grant_id_d;

    rr_select #(
        .N     (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_select (
        .valid (req_valid),
        .ptr   (ptr_q),
        .grant (gnt)
    );

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                gnt_idx = IDX_W'(i);
            end
        end
    end

    // Gating with rst_n keeps ready low for the whole asynchronous reset window.
    assign req_ready = (rst_n && !stall && !flush) ? gnt : '0;
    assign accept    = |req_ready;

    always_comb begin
        ptr_d      = ptr_q;
        wr_en_d    = wr_en_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        grant_id_d = grant_id_q;
        if (flush) begin
            wr_en_d = WE_NONE;
        end else if (stall) begin
            wr_en_d = wr_en_q;
        end else if (accept) begin
            // x0 is hardwired; size 00 already maps to no write.
            wr_en_d    = (req_rd[gnt_idx] == '0) ? WE_NONE : req_size[gnt_idx];
            wr_addr_d  = req_rd[gnt_idx];
            wr_data_d  = req_data[gnt_idx];
            grant_id_d = 2'(gnt_idx);
            ptr_d      = gnt_idx;
        end else begin
            wr_en_d = WE_NONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= IDX_W'(NREQ - 1);
            wr_en_q    <= WE_NONE;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            grant_id_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            grant_id_q <= grant_id_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign grant_id = grant_id_q;

endmodule
